// File: rtl/mat_acc_pkg.sv
// Shared parameters, FSM state type and cell-index helper for the MAC result unit.
// Contents: DATA_W, ACC_W, N, ACC_MAX, derived widths, state_t {ACC, DRAIN, DONE},
//           cell_idx(r, c) returning the row-major index 3*r + c.
package mat_acc_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ACC_W   = 10;
    localparam int unsigned N       = 3;
    localparam int unsigned ACC_MAX = 1023;
    localparam int unsigned NCELL   = N * N;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned DIM_W   = 2;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Row-major cell index for an (r, c) cursor.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c);
        return IDX_W'(r) * IDX_W'(N) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/mac_cell.sv
// One multiply-accumulate cell: acc += w*x when ld, clears when clr (ld wins).
// Ports: clk, rst (sync, active-high), i_w/i_x operands, i_ld, i_clr, o_acc_out.
// Build option: MAC_SAT_EN saturates the accumulator at ACC_MAX instead of wrapping.
module mac_cell
    import mat_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_w,
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_ld,
    input  logic              i_clr,
    output logic [ACC_W-1:0]  o_acc_out
);

    logic [ACC_W-1:0]  r_acc;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_next;

    assign w_prod = i_w * i_x;

`ifdef MAC_SAT_EN
    localparam int unsigned SUM_W = ACC_W + 1;
    logic [SUM_W-1:0] w_sum;
    // One extra bit catches the overflow; a saturated value stays pinned.
    assign w_sum  = SUM_W'(r_acc) + SUM_W'(w_prod);
    assign w_next = (w_sum > SUM_W'(ACC_MAX)) ? ACC_W'(ACC_MAX) : w_sum[ACC_W-1:0];
`else
    assign w_next = r_acc + ACC_W'(w_prod);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_ld) begin
            r_acc <= w_next;
        end else if (i_clr) begin
            r_acc <= '0;
        end
    end

    assign o_acc_out = r_acc;

endmodule

// File: rtl/mac_result_unit.sv
// 3x3 MAC array with snapshot-and-drain result streaming over a valid/ready port.
// Inputs : clk, rst (sync, active-high), data_outw1..3 (row operands),
//          data_outx1..3 (column operands), ld_mac/clear_mac (per cell, i = 3*r + c),
//          unload_res (rising edge starts a drain), row_w/col_x (drain dims), res_ready.
// Outputs: res_data/res_idx/res_valid (result stream), busy (draining), done (pulse).
// Build option: MAC_SAT_EN selects saturating accumulators (see mac_cell).
module mac_result_unit
    import mat_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_outw1,
    input  logic [DATA_W-1:0] data_outw2,
    input  logic [DATA_W-1:0] data_outw3,
    input  logic [DATA_W-1:0] data_outx1,
    input  logic [DATA_W-1:0] data_outx2,
    input  logic [DATA_W-1:0] data_outx3,
    input  logic [NCELL-1:0]  ld_mac,
    input  logic [NCELL-1:0]  clear_mac,
    input  logic              unload_res,
    input  logic [DIM_W-1:0]  row_w,
    input  logic [DIM_W-1:0]  col_x,
    output logic [ACC_W-1:0]  res_data,
    output logic [IDX_W-1:0]  res_idx,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    logic [DATA_W-1:0] w_w [N];
    logic [DATA_W-1:0] w_x [N];
    logic [ACC_W-1:0]  w_acc [NCELL];
    logic [ACC_W-1:0]  r_res [NCELL];

    state_t           r_state;
    logic             r_unload_q;
    logic [DIM_W-1:0] r_row_w;
    logic [DIM_W-1:0] r_col_x;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;

    logic             w_rise;
    logic             w_accept;
    logic             w_last_col;
    logic             w_last;
    logic [DIM_W-1:0] w_nxt_row;
    logic [DIM_W-1:0] w_nxt_col;
    logic [IDX_W-1:0] w_nxt_idx;

    assign w_w[0] = data_outw1;
    assign w_w[1] = data_outw2;
    assign w_w[2] = data_outw3;
    assign w_x[0] = data_outx1;
    assign w_x[1] = data_outx2;
    assign w_x[2] = data_outx3;

    // Cell (r, c) multiplies row operand r by column operand c.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            mac_cell u_cell (
                .clk       (clk),
                .rst       (rst),
                .i_w       (w_w[gr]),
                .i_x       (w_x[gc]),
                .i_ld      (ld_mac[gr*N+gc]),
                .i_clr     (clear_mac[gr*N+gc]),
                .o_acc_out (w_acc[gr*N+gc])
            );
        end
    end

    // Drain cursor: row-major walk bounded by the latched dimensions.
    assign w_rise     = unload_res & ~r_unload_q;
    assign w_accept   = res_valid & res_ready;
    assign w_last_col = (r_col == r_col_x - 2'd1);
    assign w_last     = w_last_col && (r_row == r_row_w - 2'd1);
    assign w_nxt_col  = w_last_col ? 2'd0 : r_col + 2'd1;
    assign w_nxt_row  = w_last_col ? r_row + 2'd1 : r_row;
    assign w_nxt_idx  = cell_idx(w_nxt_row, w_nxt_col);

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ACC;
            r_unload_q <= 1'b0;
            r_row_w    <= '0;
            r_col_x    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_res      <= '{default: '0};
            res_data   <= '0;
            res_idx    <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_unload_q <= unload_res;
            case (r_state)
                ACC: begin
                    if (w_rise) begin
                        r_res   <= w_acc;
                        r_row_w <= row_w;
                        r_col_x <= col_x;
                        r_row   <= '0;
                        r_col   <= '0;
                        if (row_w == 2'd0 || col_x == 2'd0) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            // First element comes straight from the live accumulator,
                            // which is the value being snapshotted on this edge.
                            r_state   <= DRAIN;
                            busy      <= 1'b1;
                            res_valid <= 1'b1;
                            res_data  <= w_acc[0];
                            res_idx   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state   <= DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_row    <= w_nxt_row;
                            r_col    <= w_nxt_col;
                            res_idx  <= w_nxt_idx;
                            res_data <= r_res[w_nxt_idx];
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= ACC;
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_unit.sv
// Directed self-checking bench for mac_result_unit.
module tb_mac_result_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] w_op [3];
    logic [3:0] x_op [3];
    logic [8:0] ld_mac;
    logic [8:0] clear_mac;
    logic       unload_res;
    logic [1:0] row_w;
    logic [1:0] col_x;
    logic [9:0] res_data;
    logic [3:0] res_idx;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    int n_res;
    int n_done;
    int stall_err;
    int got_d [16];
    int got_i [16];

    always #5 clk = ~clk;

    mac_result_unit dut (
        .clk        (clk),
        .rst        (rst),
        .data_outw1 (w_op[0]),
        .data_outw2 (w_op[1]),
        .data_outw3 (w_op[2]),
        .data_outx1 (x_op[0]),
        .data_outx2 (x_op[1]),
        .data_outx3 (x_op[2]),
        .ld_mac     (ld_mac),
        .clear_mac  (clear_mac),
        .unload_res (unload_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_all();
        ld_mac    = '0;
        clear_mac = 9'h1FF;
        tick();
        clear_mac = '0;
    endtask

    task automatic load_cell(input int i, input logic [3:0] wv, input logic [3:0] xv,
                             input int times);
        w_op[i/3] = wv;
        x_op[i%3] = xv;
        ld_mac    = 9'(1) << i;
        repeat (times) tick();
        ld_mac    = '0;
    endtask

    // Records accepted elements, done cycles and any stall-stability violation.
    task automatic collect(input int budget, input bit toggle);
        logic       pv;
        logic       pr;
        logic [9:0] pd;
        logic [3:0] pi;
        int         after;
        n_res = 0; n_done = 0; stall_err = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; after = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pv && !pr && (res_valid !== 1'b1 || res_data !== pd || res_idx !== pi))
                stall_err++;
            res_ready = toggle ? cyc[0] : 1'b1;
            if (res_valid === 1'b1 && res_ready) begin
                if (n_res < 16) begin
                    got_d[n_res] = int'(res_data);
                    got_i[n_res] = int'(res_idx);
                end
                n_res++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (after < 0) after = 0;
            end
            pv = res_valid; pr = res_ready; pd = res_data; pi = res_idx;
            tick();
            if (after >= 0) begin
                after++;
                if (after > 3) break;
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_reset();
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
        tests++; if (res_data !== 10'd0) begin fails++; $display("FAIL reset_data: got %0d want 0", res_data); end
        tests++; if (res_idx !== 4'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", res_idx); end
    endtask

    task automatic test_identity();
        clear_all();
        for (int i = 0; i < 9; i++) load_cell(i, 4'd1, ((i / 3) == (i % 3)) ? 4'd1 : 4'd0, 1);
        res_ready = 1'b1; row_w = 2'd3; col_x = 2'd3; unload_res = 1'b1;
        tick();
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL ident_latency_valid: got %0b want 1", res_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ident_busy: got %0b want 1", busy); end
        collect(40, 1'b0);
        tests++; if (n_res != 9) begin fails++; $display("FAIL ident_count: got %0d want 9", n_res); end
        for (int i = 0; i < 9 && i < n_res; i++) begin
            tests++; if (got_i[i] != i) begin fails++; $display("FAIL ident_idx[%0d]: got %0d want %0d", i, got_i[i], i); end
            tests++; if (got_d[i] != ((i % 4 == 0) ? 1 : 0)) begin fails++; $display("FAIL ident_data[%0d]: got %0d want %0d", i, got_d[i], (i % 4 == 0) ? 1 : 0); end
        end
        tests++; if (n_done != 1) begin fails++; $display("FAIL ident_done_pulses: got %0d want 1", n_done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ident_busy_after: got %0b want 0", busy); end
        unload_res = 1'b0;
        tick();
    endtask

    task automatic test_dims();
        clear_all();
        w_op[0] = 4'd15; w_op[1] = 4'd15; w_op[2] = 4'd15;
        x_op[0] = 4'd15; x_op[1] = 4'd15; x_op[2] = 4'd15;
        ld_mac = 9'h1FF;
        repeat (3) tick();
        ld_mac = '0;
        row_w = 2'd2; col_x = 2'd1; unload_res = 1'b1;
        tick();
        collect(20, 1'b0);
        tests++; if (n_res != 2) begin fails++; $display("FAIL dims_count: got %0d want 2", n_res); end
        tests++; if (got_i[0] != 0) begin fails++; $display("FAIL dims_idx0: got %0d want 0", got_i[0]); end
        tests++; if (got_i[1] != 3) begin fails++; $display("FAIL dims_idx1: got %0d want 3", got_i[1]); end
        tests++; if (got_d[0] != 675) begin fails++; $display("FAIL dims_data0: got %0d want 675", got_d[0]); end
        tests++; if (got_d[1] != 675) begin fails++; $display("FAIL dims_data1: got %0d want 675", got_d[1]); end
        tests++; if (n_done != 1) begin fails++; $display("FAIL dims_done_pulses: got %0d want 1", n_done); end
        unload_res = 1'b0;
        tick();
    endtask

    // Cell (r,c) holds (r+1)*(c+2) so every element is distinguishable.
    task automatic load_pattern();
        clear_all();
        for (int i = 0; i < 9; i++) load_cell(i, 4'((i / 3) + 1), 4'((i % 3) + 2), 1);
    endtask

    task automatic test_stall();
        load_pattern();
        res_ready = 1'b1; row_w = 2'd3; col_x = 2'd3; unload_res = 1'b1;
        tick();
        collect(60, 1'b1);
        tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold: got %0d violations want 0", stall_err); end
        tests++; if (n_res != 9) begin fails++; $display("FAIL stall_count: got %0d want 9", n_res); end
        for (int i = 0; i < 9 && i < n_res; i++) begin
            tests++; if (got_i[i] != i) begin fails++; $display("FAIL stall_idx[%0d]: got %0d want %0d", i, got_i[i], i); end
            tests++; if (got_d[i] != ((i / 3) + 1) * ((i % 3) + 2)) begin fails++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, got_d[i], ((i / 3) + 1) * ((i % 3) + 2)); end
        end
        tests++; if (n_done != 1) begin fails++; $display("FAIL stall_done_pulses: got %0d want 1", n_done); end
        unload_res = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int exp;
`ifdef MAC_SAT_EN
        exp = 1023;
`else
        exp = 101;
`endif
        clear_all();
        load_cell(0, 4'd15, 4'd15, 5);
        row_w = 2'd1; col_x = 2'd1; unload_res = 1'b1;
        tick();
        collect(20, 1'b0);
        tests++; if (n_res != 1) begin fails++; $display("FAIL ovf_count: got %0d want 1", n_res); end
        tests++; if (got_i[0] != 0) begin fails++; $display("FAIL ovf_idx: got %0d want 0", got_i[0]); end
        tests++; if (got_d[0] != exp) begin fails++; $display("FAIL ovf_data: got %0d want %0d", got_d[0], exp); end
        unload_res = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        load_pattern();
        res_ready = 1'b1; row_w = 2'd3; col_x = 2'd3; unload_res = 1'b1;
        tick();
        tests++; if (res_idx !== 4'd0) begin fails++; $display("FAIL rmid_first_idx: got %0d want 0", res_idx); end
        tick();
        tests++; if (res_idx !== 4'd1 || res_data !== 10'd3) begin fails++; $display("FAIL rmid_second: got idx %0d data %0d want idx 1 data 3", res_idx, res_data); end
        rst = 1'b1; unload_res = 1'b0;
        tick();
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b want 0", res_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rmid_done: got %0b want 0", done); end
        tests++; if (res_data !== 10'd0 || res_idx !== 4'd0) begin fails++; $display("FAIL rmid_outputs: got data %0d idx %0d want 0 0", res_data, res_idx); end
        rst = 1'b0;
        tick();
        unload_res = 1'b1;
        tick();
        tests++; if (res_valid !== 1'b1 || res_idx !== 4'd0) begin fails++; $display("FAIL rmid_restart: got valid %0b idx %0d want 1 0", res_valid, res_idx); end
        collect(40, 1'b0);
        tests++; if (n_res != 9) begin fails++; $display("FAIL rmid_count: got %0d want 9", n_res); end
        for (int i = 0; i < 9 && i < n_res; i++) begin
            tests++; if (got_i[i] != i || got_d[i] != 0) begin fails++; $display("FAIL rmid_elem[%0d]: got idx %0d data %0d want idx %0d data 0", i, got_i[i], got_d[i], i); end
        end
        unload_res = 1'b0;
        tick();
    endtask

    task automatic test_zero_dim();
        int extra_valid;
        int extra_done;
        load_pattern();
        row_w = 2'd0; col_x = 2'd2; unload_res = 1'b1;
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %0b want 1", done); end
        tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_valid_busy: got %0b %0b want 0 0", res_valid, busy); end
        extra_valid = 0; extra_done = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (res_valid === 1'b1) extra_valid++;
            if (done === 1'b1) extra_done++;
        end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL zero_retrigger_done: got %0d want 0", extra_done); end
        tests++; if (extra_valid != 0) begin fails++; $display("FAIL zero_retrigger_valid: got %0d want 0", extra_valid); end
        unload_res = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_op[i] = '0;
            x_op[i] = '0;
        end
        ld_mac = '0; clear_mac = '0; unload_res = 1'b0;
        row_w = '0; col_x = '0; res_ready = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_identity();
        test_dims();
        test_stall();
        test_overflow();
        test_reset_mid_drain();
        test_zero_dim();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
